instr_loader: RTL and testbench

Boot-time instruction loader sitting directly upstream of the 5-stage `pipeline` core. Accepts a byte stream over a valid/ready handshake, assembles instruction words, writes them sequentially into instruction memory from address 0, and holds the core in reset until the image is complete. On completion it releases the core's active-low reset. A `reload` pulse re-enters load mode.

---
 rtl/instr_loader.sv | 143 ++++++++++++++
 tb/tb_instr_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time instruction loader: assembles a big-endian byte stream into words,
// writes them to instruction memory from address 0, and holds the core in reset until done.
module instr_loader #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   reload,
  output logic                   imem_we,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   pipe_RST,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned BPW = INSTR_WIDTH / 8;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned AW  = PC_WIDTH + 1;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    LOAD,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t                 state, state_next;
  logic [15:0]            word_cnt;
  logic [AW-1:0]          addr;
  logic [BCW-1:0]         byte_cnt;
  logic [INSTR_WIDTH-1:0] asm_word, asm_next;
  logic [15:0]            cnt_rx;
  logic                   xfer, last_byte, last_word, cnt_over;

  assign xfer      = in_valid && in_ready;
  assign asm_next  = (asm_word << 8) | INSTR_WIDTH'(in_data);
  assign last_byte = (byte_cnt == BCW'(BPW - 1));
  // Address is one bit wider than imem_addr so a full-capacity image ends without wrapping.
  assign last_word = ((32'(addr) + 32'd1) == 32'(word_cnt));
  assign cnt_rx    = {word_cnt[15:8], in_data};
  assign cnt_over  = (32'(cnt_rx) > (32'd1 << PC_WIDTH));

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= CNT_HI;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      CNT_HI: if (xfer) state_next = CNT_LO;
      CNT_LO: begin
        if (xfer) begin
          if (cnt_rx == 16'd0) state_next = DONE;
          else if (cnt_over)   state_next = ERR;
          else                 state_next = LOAD;
        end
      end
      LOAD:      if (xfer && last_byte) state_next = WRITE;
      WRITE:     state_next = last_word ? DONE : LOAD;
      DONE, ERR: if (reload) state_next = CNT_HI;
      default:   state_next = CNT_HI;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      CNT_HI, CNT_LO, LOAD: in_ready = 1'b1;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      ERR: begin
        busy = 1'b0;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      word_cnt  <= '0;
      addr      <= '0;
      byte_cnt  <= '0;
      asm_word  <= '0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
      pipe_RST  <= 1'b0;
    end else begin
      imem_we  <= 1'b0;
      // Tracking next state makes the core reset follow DONE entry and reload exit in lockstep.
      pipe_RST <= (state_next == DONE);
      unique case (state)
        CNT_HI: if (xfer) word_cnt[15:8] <= in_data;
        CNT_LO: begin
          if (xfer) begin
            word_cnt[7:0] <= in_data;
            addr          <= '0;
            byte_cnt      <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            asm_word <= asm_next;
            if (last_byte) begin
              byte_cnt  <= '0;
              imem_we   <= 1'b1;
              imem_addr <= addr[PC_WIDTH-1:0];
              imem_data <= asm_next;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: if (!last_word) addr <= addr + 1'b1;
        DONE, ERR: begin
          if (reload) begin
            word_cnt <= '0;
            addr     <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: byte images are decoded by a stream-level
// model into expected memory writes and compared against writes observed on imem.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        pipe_RST, busy, done, err;

  always #5 clk = ~clk;

  instr_loader #(.PC_WIDTH(8), .INSTR_WIDTH(32)) dut (
    .clk(clk), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .pipe_RST(pipe_RST), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [7:0]  img[$];
  int          cyc = 0;
  int          last_we_cyc, rise_cyc, we_run, we_run_max, stall_cnt;
  logic        pipe_prev = 1'b0;

  // Passive monitor: records every write and a few timing facts per cycle.
  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      obs_q.push_back({imem_addr, imem_data});
      last_we_cyc = cyc;
      we_run++;
      if (we_run > we_run_max) we_run_max = we_run;
    end else begin
      we_run = 0;
    end
    if (pipe_RST && !pipe_prev) rise_cyc = cyc;
    pipe_prev = pipe_RST;
    if (RST && busy && !in_ready) stall_cnt++;
  end

  task automatic clear_mon();
    obs_q.delete();
    we_run = 0;
    we_run_max = 0;
    stall_cnt = 0;
    rise_cyc = -1;
    last_we_cyc = -1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
      if (t > 200) begin
        checks++;
        errors++;
        $display("FAIL send_byte timeout: byte %h never accepted", b);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_end(input string name);
    bit hit = 0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (done || err) begin
        hit = 1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s end_timeout: done/err never asserted", name);
    end
  endtask

  task automatic make_image(input int n);
    img.delete();
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
  endtask

  // Decode img by the stream rules, drive it, then compare the outcome.
  task automatic run_image(input string name, input int gap_mode, input int reload_at);
    int          n, nsend, g;
    bit          bad;
    logic [31:0] d;
    n   = int'(img[0]) * 256 + int'(img[1]);
    bad = (n > 256);
    exp_q.delete();
    if (!bad) begin
      for (int w = 0; w < n; w++) begin
        d = 0;
        for (int b = 0; b < 4; b++) d = d * 256 + 32'(img[2 + 4 * w + b]);
        exp_q.push_back({8'(w), d});
      end
    end
    clear_mon();
    nsend = bad ? 2 : img.size();
    for (int i = 0; i < nsend; i++) begin
      if (i == reload_at) pulse_reload();
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(img[i], g);
    end
    wait_end(name);
    if (bad) begin
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL %s err: got %b exp 1", name, err); end
      checks++; if (pipe_RST !== 1'b0) begin errors++; $display("FAIL %s pipe_RST: got %b exp 0", name, pipe_RST); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready: got %b exp 0", name, in_ready); end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL %s writes: got %0d exp 0", name, obs_q.size()); end
    end else begin
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b exp 1", name, done); end
      checks++; if (pipe_RST !== 1'b1) begin errors++; $display("FAIL %s pipe_RST: got %b exp 1", name, pipe_RST); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL %s write_count: got %0d exp %0d", name, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s write[%0d]: got %h@%h exp %h@%h", name, i, obs_q[i].d, obs_q[i].a, exp_q[i].d, exp_q[i].a);
        end
      end
      if (n > 0) begin
        checks++; if (rise_cyc != last_we_cyc + 1) begin errors++; $display("FAIL %s pipe_rise_cycle: got %0d exp %0d", name, rise_cyc, last_we_cyc + 1); end
        checks++; if (we_run_max != 1) begin errors++; $display("FAIL %s we_pulse_width: got %0d exp 1", name, we_run_max); end
      end
    end
  endtask

  task automatic to_idle();
    if (done || err) pulse_reload();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pipe_RST !== 1'b0) begin errors++; $display("FAIL reset pipe_RST: got %b exp 0", pipe_RST); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset imem_we: got %b exp 0", imem_we); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset imem_addr: got %h exp 00", imem_addr); end
    checks++; if (imem_data !== 32'h0) begin errors++; $display("FAIL reset imem_data: got %h exp 0", imem_data); end
    checks++; if ({done, err, busy} !== 3'b001) begin errors++; $display("FAIL reset done_err_busy: got %b exp 001", {done, err, busy}); end
    in_valid = 1'b0;
    RST = 1'b1;
    @(negedge clk);
    checks++; if ({in_ready, busy} !== 2'b11) begin errors++; $display("FAIL reset_release ready_busy: got %b exp 11", {in_ready, busy}); end
    @(posedge clk); #1;
    img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    run_image("post_reset", 0, -1);
  endtask

  task automatic test_normal_load();
    to_idle();
    img = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    run_image("normal", 0, -1);
    checks++; if (stall_cnt != 2) begin errors++; $display("FAIL normal stall_cycles: got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_gapped();
    to_idle();
    img = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    run_image("gapped", 1, -1);
  endtask

  task automatic test_limits();
    to_idle();
    make_image(0);
    run_image("n0", 0, -1);
    to_idle();
    make_image(256);
    run_image("n256", 0, -1);
    checks++; if (obs_q.size() == 0 || obs_q[obs_q.size() - 1].a !== 8'hFF) begin errors++; $display("FAIL n256 last_addr: got %h exp ff", (obs_q.size() == 0) ? 8'h00 : obs_q[obs_q.size() - 1].a); end
    to_idle();
    img = '{8'h01, 8'h01};
    run_image("n257", 0, -1);
    in_valid = 1'b1;
    in_data = 8'h5A;
    repeat (4) begin
      @(negedge clk);
      checks++; if ({in_ready, err, pipe_RST} !== 3'b010) begin errors++; $display("FAIL err_hold ready_err_pipe: got %b exp 010", {in_ready, err, pipe_RST}); end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulse_reload();
    checks++; if ({err, busy, in_ready, pipe_RST} !== 4'b0110) begin errors++; $display("FAIL err_reload err_busy_ready_pipe: got %b exp 0110", {err, busy, in_ready, pipe_RST}); end
  endtask

  task automatic test_reload();
    to_idle();
    make_image(1);
    run_image("pre_reload", 0, -1);
    pulse_reload();
    checks++; if ({pipe_RST, done, busy} !== 3'b001) begin errors++; $display("FAIL reload pipe_done_busy: got %b exp 001", {pipe_RST, done, busy}); end
    img = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_image("reload_image", 0, -1);
    to_idle();
    make_image(2);
    run_image("reload_midload", 0, 4);
  endtask

  task automatic test_async_reset();
    to_idle();
    make_image(2);
    clear_mon();
    for (int i = 0; i < 9; i++) send_byte(img[i], 0);
    #2;
    RST = 1'b0;
    #1;
    checks++; if ({imem_we, pipe_RST, done, err, busy} !== 5'b00001) begin errors++; $display("FAIL async_reset flags: got %b exp 00001", {imem_we, pipe_RST, done, err, busy}); end
    checks++; if ({imem_addr, imem_data} !== 40'h0) begin errors++; $display("FAIL async_reset addr_data: got %h exp 0", {imem_addr, imem_data}); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL async_reset prior_writes: got %0d exp 1", obs_q.size()); end
    @(posedge clk); #1;
    RST = 1'b1;
    make_image(2);
    run_image("after_async_reset", 0, -1);
  endtask

  task automatic test_random();
    int r, n;
    for (int it = 0; it < 15; it++) begin
      to_idle();
      r = int'($urandom_range(0, 9));
      if (r == 0)      n = 0;
      else if (r == 1) n = 257 + int'($urandom_range(0, 3000));
      else             n = int'($urandom_range(1, 6));
      if (n > 256) begin
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
      end else begin
        make_image(n);
      end
      run_image("random", 2, -1);
    end
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_gapped();
    test_limits();
    test_reload();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
